// File: rtl/vector_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : vector_alu_sequencer
// Description : Issues one 4-lane vector operation to the combinational ALU,
//               one lane per cycle, and returns the assembled 128-bit result.
// Revision    : 1.0 - initial release
// ============================================================================
module vector_alu_sequencer (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [3:0]   in_op,
   input  logic [127:0] in_vec_a,
   input  logic [127:0] in_vec_b,
   input  logic [31:0]  in_src_c,
   input  logic [7:0]   in_seed,
   output logic [3:0]   alu_control,
   output logic [31:0]  alu_src_a,
   output logic [31:0]  alu_src_b,
   output logic [31:0]  alu_src_c,
   output logic [1:0]   alu_index,
   output logic [1:0]   alu_column,
   output logic [7:0]   alu_last_data,
   input  logic [31:0]  alu_result,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_vec,
   output logic         busy
);

   localparam int         LANES       = 4;
   localparam int         c_word      = 32;
   localparam logic [1:0] c_last_lane = 2'(LANES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         r_state;
   state_t         w_next_state;
   logic [1:0]     r_lane;
   logic [3:0]     r_op;
   logic [127:0]   r_vec_a;
   logic [127:0]   r_vec_b;
   logic [31:0]    r_src_c;
   logic [7:0]     r_seed;
   logic [7:0]     r_chain;
   logic [127:0]   r_out_vec;

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (in_valid) w_next_state = RUN;
         RUN:     if (r_lane == c_last_lane) w_next_state = DONE;
         DONE:    if (out_ready) w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_lane    <= 2'd0;
         r_op      <= 4'd0;
         r_vec_a   <= '0;
         r_vec_b   <= '0;
         r_src_c   <= '0;
         r_seed    <= 8'd0;
         r_chain   <= 8'd0;
         r_out_vec <= '0;
      end else begin
         r_state <= w_next_state;
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_op    <= in_op;
                  r_vec_a <= in_vec_a;
                  r_vec_b <= in_vec_b;
                  r_src_c <= in_src_c;
                  r_seed  <= in_seed;
                  r_lane  <= 2'd0;
               end
            end
            RUN: begin
               r_out_vec[r_lane*c_word +: c_word] <= alu_result;
               r_chain <= alu_result[7:0];
               // wraps back to 0 after the last lane, ready for the next op
               r_lane  <= r_lane + 2'd1;
            end
            default: ;
         endcase
      end
   end

   // ALU inputs are forced to zero outside RUN so it never sees stale operands
   always_comb begin
      alu_control   = 4'd0;
      alu_src_a     = 32'd0;
      alu_src_b     = 32'd0;
      alu_src_c     = 32'd0;
      alu_index     = 2'd0;
      alu_column    = 2'd0;
      alu_last_data = 8'd0;
      if (r_state == RUN) begin
         alu_control   = r_op;
         alu_src_a     = r_vec_a[r_lane*c_word +: c_word];
         alu_src_b     = r_vec_b[r_lane*c_word +: c_word];
         alu_src_c     = r_src_c;
         alu_index     = r_lane;
         alu_column    = r_lane;
         alu_last_data = (r_lane == 2'd0) ? r_seed : r_chain;
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign busy      = (r_state == RUN) || (r_state == DONE);
   assign out_vec   = r_out_vec;

endmodule
`default_nettype wire

// File: tb/tb_vector_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_vector_alu_sequencer
// Description : Self-checking bench with a behavioural ALU and result model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vector_alu_sequencer;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [3:0]   in_op = 4'd0;
   logic [127:0] in_vec_a = '0;
   logic [127:0] in_vec_b = '0;
   logic [31:0]  in_src_c = '0;
   logic [7:0]   in_seed = '0;
   logic [3:0]   alu_control;
   logic [31:0]  alu_src_a, alu_src_b, alu_src_c;
   logic [1:0]   alu_index, alu_column;
   logic [7:0]   alu_last_data;
   logic [31:0]  alu_result;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [127:0] out_vec;
   logic         busy;

   int           vectors = 0;
   int           miscompares = 0;
   logic [127:0] r_hold_vec = '0;

   always #5 clk = ~clk;

   vector_alu_sequencer dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_vec_a(in_vec_a), .in_vec_b(in_vec_b), .in_src_c(in_src_c), .in_seed(in_seed),
      .alu_control(alu_control), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_src_c(alu_src_c), .alu_index(alu_index), .alu_column(alu_column),
      .alu_last_data(alu_last_data), .alu_result(alu_result),
      .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec), .busy(busy)
   );

   // Behavioural ALU: index/column and lastData feed the default op so they are observable
   function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, b, c,
                                         input logic [7:0] last, input logic [1:0] idx, col);
      case (op)
         4'b0000: return a + b;
         4'b0100: return a ^ {24'h0, last};
         default: return a + (b ^ c) + {20'h0, last, idx, col};
      endcase
   endfunction

   assign alu_result = alu_f(alu_control, alu_src_a, alu_src_b, alu_src_c,
                             alu_last_data, alu_index, alu_column);

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (in_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("wait_idle", 128'(in_ready), 128'd1);
   endtask

   // Called at a negedge while idle; returns at a negedge back in IDLE.
   task automatic run_op(input logic [3:0] op, input logic [127:0] a, b,
                         input logic [31:0] c, input logic [7:0] seed,
                         input int stall, input bit scramble);
      logic [7:0]   last;
      logic [31:0]  lane_res;
      logic [127:0] exp_vec;
      wait_idle();
      in_op = op; in_vec_a = a; in_vec_b = b; in_src_c = c; in_seed = seed;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      last = seed;
      exp_vec = r_hold_vec;
      for (int l = 0; l < 4; l++) begin
         check("run_busy",  128'({busy, in_ready, out_valid}), 128'(3'b100));
         check("run_ctrl",  128'(alu_control), 128'(op));
         check("run_idx",   128'({alu_index, alu_column}), 128'({2'(l), 2'(l)}));
         check("run_src_a", 128'(alu_src_a), 128'(a[32*l +: 32]));
         check("run_src_b", 128'(alu_src_b), 128'(b[32*l +: 32]));
         check("run_src_c", 128'(alu_src_c), 128'(c));
         check("run_last",  128'(alu_last_data), 128'(last));
         lane_res = alu_f(op, a[32*l +: 32], b[32*l +: 32], c, last, 2'(l), 2'(l));
         exp_vec[32*l +: 32] = lane_res;
         last = lane_res[7:0];
         if (scramble) begin
            in_vec_a = {$urandom, $urandom, $urandom, $urandom};
            in_vec_b = {$urandom, $urandom, $urandom, $urandom};
            in_src_c = $urandom; in_op = 4'($urandom); in_seed = 8'($urandom);
            in_valid = 1'b1;
         end
         @(negedge clk);
      end
      r_hold_vec = exp_vec;
      check("done_valid", 128'({out_valid, in_ready, busy}), 128'(3'b101));
      check("done_vec", out_vec, exp_vec);
      check("done_alu_ctrl", 128'({alu_control, alu_src_a}), 128'd0);
      in_valid = 1'b0;
      for (int s = 0; s < stall; s++) begin
         in_op = 4'($urandom); in_vec_a = {$urandom, $urandom, $urandom, $urandom};
         in_valid = (s % 2 == 0);
         @(negedge clk);
         check("stall_state", 128'({out_valid, in_ready}), 128'(2'b10));
         check("stall_vec", out_vec, exp_vec);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("hs_state", 128'({out_valid, in_ready, busy}), 128'(3'b010));
      check("hs_vec", out_vec, exp_vec);
   endtask

   task automatic reset_mid_run();
      wait_idle();
      in_op = 4'd1; in_vec_a = {4{32'h13579bdf}}; in_vec_b = {4{32'h2468ace0}};
      in_src_c = 32'h0f0f0f0f; in_seed = 8'h5a;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst_lane2", 128'(alu_index), 128'd2);
      rst = 1'b1;
      in_valid = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b0;
      check("rst_state", 128'({out_valid, in_ready, busy}), 128'(3'b010));
      check("rst_alu", 128'({alu_control, alu_src_a, alu_src_b, alu_src_c,
                             alu_index, alu_column, alu_last_data}), 128'd0);
      check("rst_vec", out_vec, 128'd0);
      r_hold_vec = '0;
      @(negedge clk);
      check("rst_no_accept", 128'(busy), 128'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("reset_state", 128'({out_valid, in_ready, busy}), 128'(3'b010));
      check("reset_alu", 128'({alu_control, alu_src_a, alu_last_data}), 128'd0);
      check("reset_vec", out_vec, 128'd0);

      run_op(4'b0000, {32'h1bc492bb, 32'h6649d86c, 32'd10, 32'd8},
             {32'd4, 32'd4, 32'd3, 32'd5}, 32'd0, 8'd0, 0, 1'b0);
      check("lane_add", r_hold_vec, {32'h1bc492bf, 32'h6649d870, 32'd13, 32'd13});

      run_op(4'b0001, {$urandom, $urandom, $urandom, $urandom},
             {$urandom, $urandom, $urandom, $urandom}, $urandom, 8'($urandom), 0, 1'b0);

      run_op(4'b0100, {4{32'h1bc492bb}}, '0, 32'd0, 8'h7c, 0, 1'b0);
      check("chain", r_hold_vec, {32'h1bc4927c, 32'h1bc492c7, 32'h1bc4927c, 32'h1bc492c7});

      run_op(4'b0000, {$urandom, $urandom, $urandom, $urandom},
             {$urandom, $urandom, $urandom, $urandom}, $urandom, 8'($urandom), 5, 1'b0);

      run_op(4'b0010, {$urandom, $urandom, $urandom, $urandom},
             {$urandom, $urandom, $urandom, $urandom}, 32'h25423513, 8'($urandom), 1, 1'b1);

      reset_mid_run();

      for (int k = 0; k < 20; k++) begin
         run_op(4'($urandom), {$urandom, $urandom, $urandom, $urandom},
                {$urandom, $urandom, $urandom, $urandom}, $urandom, 8'($urandom),
                int'($urandom_range(0, 3)), 1'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/vector_alu_sequencer.md
# vector_alu_sequencer

Upstream issue stage for the vector-encryption ALU. It accepts one 4-lane vector operation (four 32-bit words per source), then drives the combinational ALU one lane per cycle with the operands, control code, lane index/column and chained last byte. It assembles the four ALU results into a 128-bit result vector and presents it to writeback through a valid/ready handshake.

## Interface
- LANES, 4, lanes per vector; fixed at 4. Column and index are 2 bits wide.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  the upstream operation is valid.
- in_ready  out  1  the sequencer can accept an operation.
- in_op  in  4  ALU control code applied to all lanes.
- in_vec_a  in  128  SrcA lanes; lane i is bits [32i+31:32i].
- in_vec_b  in  128  SrcB lanes, same packing as in_vec_a.
- in_src_c  in  32  scalar SrcC, broadcast to every lane.
- in_seed  in  8  lastData value for lane 0.
- alu_control  out  4  to ALU ALUcontrol.
- alu_src_a / alu_src_b / alu_src_c  out  32 each  to ALU SrcA/SrcB/SrcC.
- alu_index  out  2  to ALU index.
- alu_column  out  2  to ALU column.
- alu_last_data  out  8  to ALU lastData.
- alu_result  in  32  from ALU ALUresult; combinational from alu_* outputs.
- out_valid  out  1  result vector is valid.
- out_ready  in  1  the downstream stage accepts the result.
- out_vec  out  128  results; lane i is bits [32i+31:32i].
- busy  out  1  high in the RUN and DONE states.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, register in_op, in_vec_a, in_vec_b, in_src_c and in_seed.
  - Clear lane counter to 0 and go to RUN.
- RUN, lane counter L in 0..3:
  - alu_control = op_q.
  - alu_src_a = vec_a_q lane L; alu_src_b = vec_b_q lane L; alu_src_c = src_c_q.
  - alu_index = L; alu_column = L.
  - alu_last_data = seed_q when L=0; otherwise the registered chain byte, which is alu_result[7:0] captured from lane L-1.
  - Each cycle: capture alu_result into out_vec lane L and capture alu_result[7:0] as the chain byte.
  - When L=3, go to DONE. Otherwise increment L.
- DONE:
  - out_valid=1; out_vec is held stable.
  - On out_ready, go to IDLE.
  - An operation is never accepted in the same cycle as the DONE→IDLE transition.
- ALU outputs outside RUN: all alu_* are 0. The ALU sees operands only during RUN.
- in_ready=0 in RUN and DONE. in_valid in those states is ignored and not queued.
- Operand registers are not modified outside the IDLE accept cycle. Changing in_* mid-operation has no effect.
- out_vec keeps the previous result until lane 0 of the next operation overwrites it. Only out_valid qualifies it.
- Widths:
  - alu_index and alu_column are exactly L.
  - No arithmetic is done in this block. Results pass through bit-exact.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, out_vec=0, all alu_*=0, state=IDLE, L=0, chain byte=0.
- Reset asserted in any state returns the block to IDLE on the next edge. An operation in progress is discarded and out_valid drops.
- Latency: operation accepted at edge T.
  - Lanes 0..3 are driven in cycles T+1..T+4 (one lane per cycle).
  - out_valid rises after edge T+4 and is visible in cycle T+5.
- The fastest back-to-back operation is accepted 1 cycle after the out_ready handshake. Throughput is 1 operation per 6 cycles minimum.
- out_ready held low keeps the block in DONE indefinitely, with out_vec stable.
- Simultaneous rst and in_valid: rst wins and nothing is accepted.
- Simultaneous rst and out_ready in DONE: rst wins.

## Test plan
- Reset: assert rst for 2 cycles in mid-RUN (lane 2).
  - Next cycle: out_valid=0, in_ready=1, alu_*=0, out_vec=0.
- Lane add: bench ALU model returns src_a+src_b for op 0000.
  - Stimulus: vec_a lanes {8,10,32'h6649d86c,32'h1bc492bb}, vec_b lanes {5,3,4,4}.
  - Response: out_vec lanes {13,13,32'h6649d870,32'h1bc492bf}; out_valid in cycle T+5.
- Index/column sweep, op 0001:
  - alu_index and alu_column read 0,1,2,3 in cycles T+1..T+4.
  - alu_control=0001 in those cycles and 0 otherwise.
- Chaining, op 0100: bench model returns src_a ^ {24'h0,last_data}.
  - Stimulus: seed 8'h7c, all vec_a lanes 32'h1bc492bb.
  - alu_last_data sequence: 7c, c7, 7c, c7.
  - out_vec lanes: 1bc492c7, 1bc4927c, 1bc492c7, 1bc4927c.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid.
  - out_vec is stable and in_ready=0 throughout.
  - in_valid pulsed during the stall with a new operation is not accepted.
  - After out_ready=1, out_valid drops and the next operation is accepted one cycle later.
- Operand isolation: change in_vec_a and in_src_c every cycle during RUN.
  - Results match the operands registered at the accept cycle.
  - alu_src_c equals the captured scalar, e.g. 32'h25423513, in every lane.
